detect_monitor: RTL and testbench

Downstream stage of the decoder: consumes its raw `indicate` flag and turns it into a debounced detection signal with minimum-hold stretching. It counts qualified detections and raises a sticky interrupt. It exposes control/status on the same `writ`/`address`/`data` register bus the decoder uses, plus a read port.

---
 rtl/detect_monitor_pkg.sv | 28 ++
 rtl/dm_regs.sv | 87 ++++++++
 rtl/detect_monitor.sv | 169 ++++++++++++++++
 tb/tb_detect_monitor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_monitor_pkg.sv
// Shared types and constants for the detect_monitor block: FSM state encoding,
// register indices and CTRL/STATUS bit positions.
package detect_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    ACTIVE   = 2'd2,
    QUAL_OFF = 2'd3
  } dm_state_t;

  localparam logic [2:0] DM_CTRL   = 3'd0;
  localparam logic [2:0] DM_STATUS = 3'd1;
  localparam logic [2:0] DM_COUNT  = 3'd2;
  localparam logic [2:0] DM_TSTAMP = 3'd3;

  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int CTRL_CNT_CLR_BIT   = 2;
  localparam int STATUS_DETECT_BIT  = 0;
  localparam int STATUS_PENDING_BIT = 1;

  // The block owns the first eight word slots of the shared register bus.
  function automatic logic dm_block_hit(input logic [4:0] address);
    return address[4:3] == 2'b00;
  endfunction

endpackage

// File: rtl/dm_regs.sv
// Register decode, registered readback and the sticky pending/irq logic for
// detect_monitor.
module dm_regs
  import detect_monitor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        writ,
  input  logic        read,
  input  logic [4:0]  address,
  input  logic [31:0] data,
  input  logic        detect,
  input  logic        set_pending,
  input  logic [31:0] count,
  input  logic [31:0] tstamp,
  output logic [31:0] rdata,
  output logic        enable,
  output logic        irq_en,
  output logic        cnt_clr,
  output logic        irq
);

  // Bus protocol: writ and read are single-cycle strobes qualified by the
  // address decode and sampled at the rising edge; there is no back-pressure,
  // rdata updates on the edge that samples read and holds until the next read.
  logic        hit;
  logic        ctrl_wr;
  logic        status_wr;
  logic        pending;
  logic [31:0] rd_mux;
  logic        unused_data;

  assign hit       = dm_block_hit(address);
  assign ctrl_wr   = writ && hit && (address[2:0] == DM_CTRL);
  assign status_wr = writ && hit && (address[2:0] == DM_STATUS);
  assign cnt_clr   = ctrl_wr && data[CTRL_CNT_CLR_BIT];
  assign irq       = pending && irq_en;

  assign unused_data = ^data[31:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= data[CTRL_ENABLE_BIT];
      irq_en <= data[CTRL_IRQ_EN_BIT];
    end
  end

  // A new detection wins over a simultaneous write-one-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (set_pending) begin
      pending <= 1'b1;
    end else if (status_wr && data[STATUS_PENDING_BIT]) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address[2:0])
      DM_CTRL: begin
        rd_mux[CTRL_ENABLE_BIT] = enable;
        rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
      end
      DM_STATUS: begin
        rd_mux[STATUS_DETECT_BIT]  = detect;
        rd_mux[STATUS_PENDING_BIT] = pending;
      end
      DM_COUNT:  rd_mux = count;
      DM_TSTAMP: rd_mux = tstamp;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (read && hit) begin
      rdata <= rd_mux;
    end
  end

endmodule

// File: rtl/detect_monitor.sv
// Debounce + minimum-hold stretcher for the decoder's indicate flag, with a
// saturating event counter and sticky interrupt. Define DETECT_MONITOR_TSTAMP_EN
// to build the free-running cycle counter and the TSTAMP register.
module detect_monitor
  import detect_monitor_pkg::*;
#(
  parameter int DEB_CYC  = 500,
  parameter int HOLD_CYC = 50_000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        indicate_i,
  input  logic        writ,
  input  logic        read,
  input  logic [4:0]  address,
  input  logic [31:0] data,
  output logic [31:0] rdata,
  output logic        detect_o,
  output logic        irq
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int HOLD_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC);
  localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  dm_state_t         state;
  dm_state_t         next_state;
  logic              ind_r;
  logic [DEB_W-1:0]  deb;
  logic [HOLD_W-1:0] hold;
  logic [CNT_W-1:0]  count;
  logic [31:0]       count_ext;
  logic [31:0]       tstamp;
  logic              enable;
  logic              irq_en;
  logic              cnt_clr;
  logic              active_entry;
  logic              deb_done;
  logic              hold_done;
  logic              in_qual;

  assign deb_done  = (deb == DEB_MAX);
  assign hold_done = (hold == HOLD_MAX);
  assign in_qual   = (state == QUAL_ON) || (state == QUAL_OFF);
  assign count_ext = 32'(count);

  // The FSM and counters only ever see the registered copy of indicate_i.
  always_ff @(posedge clk) begin
    if (reset) begin
      ind_r <= 1'b0;
    end else begin
      ind_r <= indicate_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ind_r) next_state = QUAL_ON;
        end
        QUAL_ON: begin
          if (!ind_r)        next_state = IDLE;
          else if (deb_done) next_state = ACTIVE;
        end
        ACTIVE: begin
          if (!ind_r && hold_done) next_state = QUAL_OFF;
        end
        QUAL_OFF: begin
          if (ind_r)         next_state = ACTIVE;
          else if (deb_done) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Only a qualified rise is an event; a return from QUAL_OFF is a re-trigger.
  always_comb begin
    detect_o     = (state == ACTIVE) || (state == QUAL_OFF);
    active_entry = (state == QUAL_ON) && (next_state == ACTIVE);
  end

  // deb counts equal samples since entering a qualification state (entry = 1).
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      deb  <= '0;
      hold <= '0;
    end else begin
      if ((next_state != state) &&
          ((next_state == QUAL_ON) || (next_state == QUAL_OFF))) begin
        deb <= DEB_ONE;
      end else if (in_qual && (next_state == state) && !deb_done) begin
        deb <= deb + DEB_ONE;
      end

      if (active_entry) begin
        hold <= '0;
      end else if ((state == ACTIVE) && !hold_done) begin
        hold <= hold + HOLD_ONE;
      end
    end
  end

  // A clear coinciding with an event leaves exactly that one event counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (active_entry) begin
      if (cnt_clr)               count <= CNT_ONE;
      else if (count != CNT_MAX) count <= count + CNT_ONE;
    end else if (cnt_clr) begin
      count <= '0;
    end
  end

`ifdef DETECT_MONITOR_TSTAMP_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
      tstamp  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (active_entry) tstamp <= cyc_cnt;
    end
  end
`else
  assign tstamp = '0;
`endif

  dm_regs u_regs (
    .clk         (clk),
    .reset       (reset),
    .writ        (writ),
    .read        (read),
    .address     (address),
    .data        (data),
    .detect      (detect_o),
    .set_pending (active_entry),
    .count       (count_ext),
    .tstamp      (tstamp),
    .rdata       (rdata),
    .enable      (enable),
    .irq_en      (irq_en),
    .cnt_clr     (cnt_clr),
    .irq         (irq)
  );

endmodule

// File: tb/tb_detect_monitor.sv
// Self-checking bench for detect_monitor: directed scenarios plus randomized
// traffic, checked against a run-length based reference model.
module tb_detect_monitor;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        indicate_i = 1'b0;
  logic        writ = 1'b0;
  logic        read = 1'b0;
  logic [4:0]  address = '0;
  logic [31:0] data = '0;
  logic [31:0] rdata;
  logic        detect_o;
  logic        irq;

  always #5 clk = ~clk;

  detect_monitor #(
    .DEB_CYC  (DEB),
    .HOLD_CYC (HOLD),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .indicate_i (indicate_i),
    .writ       (writ),
    .read       (read),
    .address    (address),
    .data       (data),
    .rdata      (rdata),
    .detect_o   (detect_o),
    .irq        (irq)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Detection rises once DEB+1 consecutive enabled samples are high, and falls
  // once DEB+1 consecutive samples are low, no earlier than HOLD+DEB+1 edges
  // after the rise.
  bit          en_m, irq_en_m, pend_m, det_m, ind_q;
  int          count_m, ones, zeros, rise_cyc, cyc;
  logic [31:0] rdata_m, ts_m, tfree_m;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    bit          hit, ev, clr_now;
    logic [31:0] rv;
    if (reset) begin
      en_m = 0; irq_en_m = 0; pend_m = 0; det_m = 0;
      count_m = 0; ones = 0; zeros = 0; rise_cyc = 0; cyc = 0;
      rdata_m = '0; ts_m = '0; tfree_m = '0;
      exp_q.delete();
      ind_q = 0;
    end else begin
      hit = (address[4:3] == 2'b00);
      if (read && hit) begin
        case (address[2:0])
          3'd0: rv = {30'b0, irq_en_m, en_m};
          3'd1: rv = {30'b0, pend_m, det_m};
          3'd2: rv = 32'(count_m);
`ifdef DETECT_MONITOR_TSTAMP_EN
          3'd3: rv = ts_m;
`endif
          default: rv = '0;
        endcase
        rdata_m = rv;
        exp_q.push_back(rv);
      end
      clr_now = writ && hit && (address[2:0] == 3'd0) && data[2];
      ev = 0;
      if (!en_m) begin
        det_m = 0; ones = 0; zeros = 0;
      end else begin
        if (ind_q) begin ones++; zeros = 0; end
        else begin zeros++; ones = 0; end
        if (!det_m && ones >= DEB + 1) begin
          det_m = 1; ev = 1; rise_cyc = cyc;
        end else if (det_m && zeros >= DEB + 1 && cyc >= rise_cyc + HOLD + DEB + 1) begin
          det_m = 0;
        end
      end
      if (ev) count_m = clr_now ? 1 : ((count_m < CMAX) ? count_m + 1 : count_m);
      else if (clr_now) count_m = 0;
      if (ev) pend_m = 1;
      else if (writ && hit && (address[2:0] == 3'd1) && data[1]) pend_m = 0;
      if (ev) ts_m = tfree_m;
      tfree_m = tfree_m + 32'd1;
      if (writ && hit && (address[2:0] == 3'd0)) begin
        en_m = data[0]; irq_en_m = data[1];
      end
      cyc++;
      ind_q = indicate_i;
    end
  end

  // scoreboard: outputs compared every cycle, reads popped from exp_q
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("detect_o", {31'b0, detect_o}, {31'b0, det_m});
      check("irq", {31'b0, irq}, {31'b0, pend_m & irq_en_m});
      if (exp_q.size() > 0) check("rdata", rdata, exp_q.pop_front());
      else                  check("rdata_hold", rdata, rdata_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
    writ = 1'b1; address = {2'b00, idx}; data = d;
    @(negedge clk);
    writ = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [31:0] v);
    read = 1'b1; address = {2'b00, idx};
    @(negedge clk);
    read = 1'b0;
    v = rdata;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] v;
  logic [31:0] d;
  int          run, op, hi, lows;

  initial begin
    idle(3);
    chk_on = 1'b1;
    check("rst_detect", {31'b0, detect_o}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    idle(2);
    bus_write(3'd0, 32'h3);

    // clean detection: rise exactly DEB+1 edges after first high sample
    indicate_i = 1'b1;
    idle(5);
    check("clean_pre", {31'b0, detect_o}, 32'd0);
    idle(1);
    check("clean_rise", {31'b0, detect_o}, 32'd1);
    bus_read(3'd1, v); check("clean_status", v, 32'h3);
    bus_read(3'd2, v); check("clean_count", v, 32'd1);
    idle(22);
    indicate_i = 1'b0;
    idle(40);

    // glitch rejection
    bus_write(3'd1, 32'h2);
    bus_write(3'd0, 32'h7);
    indicate_i = 1'b1;
    idle(3);
    indicate_i = 1'b0;
    idle(20);
    bus_read(3'd2, v); check("glitch_count", v, 32'd0);

    // hold stretch
    hi = 0;
    indicate_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 6) indicate_i = 1'b0;
      @(negedge clk);
      if (detect_o) hi++;
    end
    check("hold_len", 32'(hi), 32'(HOLD + DEB + 1));
    idle(10);

    // re-trigger during release qualification
    lows = 0;
    for (int i = 0; i < 42; i++) begin
      if (i == 0)  indicate_i = 1'b1;
      if (i == 30) indicate_i = 1'b0;
      if (i == 32) indicate_i = 1'b1;
      @(negedge clk);
      if (i >= 5 && !detect_o) lows++;
    end
    indicate_i = 1'b0;
    check("retrig_nofall", 32'(lows), 32'd0);
    idle(40);
    bus_read(3'd2, v); check("retrig_count", v, 32'd2);

    // sticky interrupt
    check("irq_set", {31'b0, irq}, 32'd1);
    bus_write(3'd1, 32'h2);
    check("irq_clear", {31'b0, irq}, 32'd0);
    indicate_i = 1'b1;
    idle(5);
    bus_write(3'd1, 32'h2);
    check("irq_coincide", {31'b0, irq}, 32'd1);
    idle(20);
    indicate_i = 1'b0;
    idle(40);

    // counter saturation and clear-with-event
    bus_write(3'd0, 32'h7);
    for (int e = 0; e < 5; e++) begin
      indicate_i = 1'b1; idle(8);
      indicate_i = 1'b0; idle(30);
    end
    bus_read(3'd2, v); check("sat_count", v, 32'd3);
    indicate_i = 1'b1;
    idle(5);
    bus_write(3'd0, 32'h7);
    idle(10);
    indicate_i = 1'b0;
    idle(40);
    bus_read(3'd2, v); check("clr_coincide", v, 32'd1);

    // same-cycle CTRL write and read returns the old value
    read = 1'b1; writ = 1'b1; address = 5'd0; data = 32'h1;
    @(negedge clk);
    read = 1'b0; writ = 1'b0;
    check("ctrl_rdw", rdata, 32'h3);
    bus_read(3'd0, v); check("ctrl_new", v, 32'h1);
    bus_write(3'd0, 32'h3);

    // randomized traffic
    run = 0;
    for (int c = 0; c < 1500; c++) begin
      if (run == 0) begin
        indicate_i = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 25);
      end
      run--;
      writ = 1'b0; read = 1'b0;
      d = $urandom;
      d[0] = ($urandom_range(0, 9) != 0);
      d[2] = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 19);
      case (op)
        0: begin writ = 1'b1; address = 5'd0; data = d; end
        1: begin writ = 1'b1; address = 5'd1; data = $urandom; end
        2, 3: begin
          read = 1'b1;
          if ($urandom_range(0, 3) == 0) address = 5'($urandom);
          else address = {2'b00, 3'($urandom_range(0, 7))};
        end
        4: begin read = 1'b1; writ = 1'b1; address = 5'd0; data = d; end
        default: ;
      endcase
      @(negedge clk);
    end
    writ = 1'b0; read = 1'b0;
    indicate_i = 1'b0;
    idle(40);

    // reset during qualification
    bus_write(3'd0, 32'h3);
    indicate_i = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(10);
    check("rstq_detect", {31'b0, detect_o}, 32'd0);
    bus_read(3'd2, v); check("rstq_count", v, 32'd0);
    bus_read(3'd0, v); check("rstq_ctrl", v, 32'd0);
    indicate_i = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
